acos_search: RTL and testbench

ACOS_SEARCH -- requirements
Module: acos_search

---
 rtl/acos_pkg.sv | 28 ++
 rtl/acos_controller.sv | 79 +++++++
 rtl/acos_search.sv | 93 +++++++++
 tb/tb_acos_search.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/acos_pkg.sv
// Shared types and constants for the arc-cosine successive-approximation search.
package acos_pkg;

  localparam int ANG_W  = 10;              // angle code width, unsigned 2.8 radians
  localparam int FRAC_W = 8;               // cosine fractional bits
  localparam int INT_W  = 2;               // cosine integer bits (two's complement)
  localparam int VAL_W  = INT_W + FRAC_W;  // full cosine / target width
  localparam int BIT_W  = 4;               // width of the bit index 9..0

  localparam logic [ANG_W-1:0] XMAX_DEF = 10'h324;  // pi in 2.8
  localparam logic [FRAC_W-1:0] YCFG_DEF = 8'hFF;
  localparam logic [BIT_W-1:0] BIT_TOP  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIAL,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Candidate angle: current accumulator with the bit under test forced high.
  function automatic logic [ANG_W-1:0] set_bit(input logic [ANG_W-1:0] a,
                                               input logic [BIT_W-1:0] b);
    return a | (ANG_W'(1) << b);
  endfunction

endpackage

// File: rtl/acos_controller.sv
// Sequencing FSM for the arc-cosine search: walks the bits, issues cosine
// requests and produces the registered control strobes.
//
//   state | meaning
//   IDLE  | waiting for start
//   TRIAL | bit under test chosen; skip it if the candidate exceeds XMAX
//   ISSUE | cos_start asserted for this single cycle
//   WAIT  | waiting for cos_done from the cosine unit
//   DONE  | result valid, done asserted
module acos_controller
  import acos_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   trial_over,
  input  logic   bit_zero,
  input  logic   cos_done,
  output state_t state,
  output logic   cos_start,
  output logic   busy,
  output logic   done
);

  // State register with registered strobes; cos_start/done are set on the
  // transition into ISSUE/DONE so they are high exactly while in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cos_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cos_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_TRIAL;
            busy  <= 1'b1;
          end
        end
        ST_TRIAL: begin
          if (trial_over) begin
            if (bit_zero) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            state     <= ST_ISSUE;
            cos_start <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cos_done) begin
            if (bit_zero) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_TRIAL;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/acos_search.sv
// Arc-cosine by successive approximation: finds the largest angle code
// x <= XMAX with cos(x) >= target, using an external cosine unit.
module acos_search
  import acos_pkg::*;
#(
  parameter logic [ANG_W-1:0]  XMAX = XMAX_DEF,
  parameter logic [FRAC_W-1:0] YCFG = YCFG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [VAL_W-1:0]  target,
  input  logic              cos_done,
  input  logic [INT_W-1:0]  cos_int,
  input  logic [FRAC_W-1:0] cos_frac,
  output logic              cos_start,
  output logic [ANG_W-1:0]  cos_x,
  output logic [FRAC_W-1:0] cos_y,
  output logic              busy,
  output logic [ANG_W-1:0]  result,
  output logic              done
);

  state_t                    state;
  logic [ANG_W-1:0]          acc;
  logic [BIT_W-1:0]          bit_idx;
  logic signed [VAL_W-1:0]   target_reg;
  logic signed [VAL_W-1:0]   cos_val;
  logic [ANG_W-1:0]          trial;
  logic                      trial_over;
  logic                      bit_zero;
  logic                      cos_ge;

  assign cos_y      = YCFG;
  assign trial      = set_bit(acc, bit_idx);
  assign trial_over = (trial > XMAX);
  assign bit_zero   = (bit_idx == '0);
  assign cos_val    = {cos_int, cos_frac};
  assign cos_ge     = (cos_val >= target_reg);

  acos_controller u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .trial_over (trial_over),
    .bit_zero   (bit_zero),
    .cos_done   (cos_done),
    .state      (state),
    .cos_start  (cos_start),
    .busy       (busy),
    .done       (done)
  );

  // Search datapath; result is loaded on the same edge that enters DONE so
  // it is valid together with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      bit_idx    <= BIT_TOP;
      target_reg <= '0;
      cos_x      <= '0;
      result     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            target_reg <= target;
            acc        <= '0;
            bit_idx    <= BIT_TOP;
          end
        end
        ST_TRIAL: begin
          if (trial_over) begin
            if (bit_zero) result <= acc;
            else          bit_idx <= bit_idx - 1'b1;
          end else begin
            cos_x <= trial;
          end
        end
        ST_WAIT: begin
          if (cos_done) begin
            if (cos_ge) acc <= cos_x;
            if (bit_zero) result <= cos_ge ? cos_x : acc;
            else          bit_idx <= bit_idx - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acos_search.sv
// Bench for acos_search: cosine responder floor(256*cos(x/256)) with a
// 5-cycle latency, brute-force reference search, directed targets.
module tb_acos_search;

  localparam int XMAX_I = 804;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] target;
  logic       cos_done;
  logic [1:0] cos_int;
  logic [7:0] cos_frac;
  logic       cos_start;
  logic [9:0] cos_x;
  logic [7:0] cos_y;
  logic       busy;
  logic [9:0] result;
  logic       done;

  int total = 0;
  int bad = 0;
  int calls_cnt = 0;
  int done_cnt = 0;
  int exp_res = 0;
  int stray_cnt = 0;
  int stray_seen = 0;

  acos_search dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .target    (target),
    .cos_done  (cos_done),
    .cos_int   (cos_int),
    .cos_frac  (cos_frac),
    .cos_start (cos_start),
    .cos_x     (cos_x),
    .cos_y     (cos_y),
    .busy      (busy),
    .result    (result),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cos_fix(input int x);
    return $rtoi($floor(256.0 * $cos(real'(x) / 256.0)));
  endfunction

  // Reference: largest code in [0, XMAX] whose cosine is >= t, else 0.
  function automatic int model_acos(input int t);
    int r = 0;
    for (int x = 0; x <= XMAX_I; x++)
      if (cos_fix(x) >= t) r = x;
    return r;
  endfunction

  // Cosine unit: answers each request 5 cycles after it sees cos_start;
  // also injects stray completions on request from the main sequence.
  initial begin
    int pending;
    int xcap;
    logic [9:0] v;
    pending = 0;
    xcap = 0;
    cos_done = 1'b0;
    cos_int = '0;
    cos_frac = '0;
    forever begin
      @(posedge clk);
      #1;
      cos_done = 1'b0;
      if (rst) pending = 0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          v = 10'(cos_fix(xcap));
          {cos_int, cos_frac} = v;
          cos_done = 1'b1;
        end
      end
      if (cos_start) begin
        xcap = int'(cos_x);
        pending = 5;
      end
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        {cos_int, cos_frac} = 10'h100;
        cos_done = 1'b1;
      end
    end
  end

  // Per-cycle compare against the reference and protocol rules.
  initial begin
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("cos_y_const", int'(cos_y), 255);
        if (cos_start) begin
          calls_cnt++;
          if (prev_start) check("cos_start_width", 2, 1);
        end
        if (done) begin
          done_cnt++;
          check("result_vs_model", int'(result), exp_res);
          check("busy_in_done", int'(busy), 1);
        end
      end
      prev_start = cos_start;
    end
  end

  task automatic launch(input logic [9:0] tgt);
    @(posedge clk);
    #1;
    exp_res = model_acos(int'($signed(tgt)));
    target = tgt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input string name, input logic [9:0] tgt,
                     input int exp_lit, input int exp_calls);
    int c0;
    int d0;
    bit got;
    c0 = calls_cnt;
    d0 = done_cnt;
    launch(tgt);
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) check({name, "_timeout"}, 0, 1);
    check({name, "_result"}, int'(result), exp_lit);
    @(negedge clk);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_done_low"}, int'(done), 0);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_held"}, int'(result), exp_lit);
    if (exp_calls >= 0) check({name, "_calls"}, calls_cnt - c0, exp_calls);
  endtask

  initial begin
    int c0;
    int d0;
    bit got;
    rst = 1'b1;
    start = 1'b0;
    target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_cos_start", int'(cos_start), 0);
    check("rst_done", int'(done), 0);
    check("rst_cos_x", int'(cos_x), 0);
    check("rst_result", int'(result), 0);
    check("rst_cos_y", int'(cos_y), 255);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run("t_zero",  10'h000, 402, 10);
    run("t_m0p5",  10'h380, 536, 10);
    run("t_m2p0",  10'h200, 804, 4);
    run("t_above", 10'h101, 0,   10);

    // Stray completions while idle, then a repeated start during WAIT.
    stray_cnt++;
    repeat (3) @(posedge clk);
    stray_cnt++;
    repeat (3) @(posedge clk);
    check("stray_idle_busy", int'(busy), 0);
    fork
      run("t_restart", 10'h380, 536, 10);
      begin
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        target = 10'h000;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join

    // Abort during the WAIT of the third call.
    c0 = calls_cnt;
    launch(10'h000);
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clk);
      if (calls_cnt - c0 >= 3) got = 1'b1;
    end
    if (!got) check("abort_reach_call3", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cos_start", int'(cos_start), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_cos_x", int'(cos_x), 0);
    check("abort_result", int'(result), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    c0 = calls_cnt;
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("abort_no_calls", calls_cnt - c0, 0);
    check("abort_no_done", done_cnt - d0, 0);
    run("t_after_rst", 10'h380, 536, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
